alu_sweep_driver: RTL
=====================

Name: alu_sweep_driver

Overview:
- Synthesizable initiator for the 8-bit ALU command interface: a, b, 4-bit command, enable, 16-bit result y.
- On start, sweeps every (a, b, command) combination in a fixed order and drives each vector for a programmable number of cycles.
- Captures y for each vector and folds it into a 16-bit rotate-XOR signature.
- Used for on-chip self-test of the ALU and as the reusable stimulus engine for ALU benches.

Parameters:
- A_MAX, 15, last a value swept (0..255).
- B_MAX, 15, last b value swept (0..255).
- HOLD, 1, cycles each vector is driven before the capture cycle (>=1).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- abort  input  1  terminate a sweep; sampled in every state.
- alu_y  input  16  ALU result.
- alu_a  output  8  operand a to ALU.
- alu_b  output  8  operand b to ALU.
- alu_cmd  output  4  ALU command code.
- alu_en  output  1  ALU output enable.
- busy  output  1  high from the cycle after start until return to IDLE.
- done  output  1  one-cycle pulse on normal completion.
- signature  output  16  running result signature.
- vec_count  output  21  number of vectors captured in current/last sweep.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0, including signature and vec_count. Takes effect immediately, including mid-sweep. Sweep restarts only on a new start after release.
- States: IDLE, ISSUE, CAPTURE, DONE.
- IDLE:
  - alu_en=0, alu_a/alu_b/alu_cmd=0, busy=0.
  - start=1 and abort=0 -> ISSUE. On the same edge: a=b=cmd=0, signature=0, vec_count=0, hold counter=0.
  - start and abort both high: abort wins, stay IDLE.
- ISSUE:
  - alu_en=1, busy=1; operands driven from internal a/b/cmd counters and stable.
  - Hold counter increments each cycle. After HOLD cycles in ISSUE -> CAPTURE.
- CAPTURE: one cycle.
  - alu_en=1, operands unchanged.
  - On the exit edge: signature <= {signature[14:0], signature[15]} ^ alu_y; vec_count <= vec_count+1.
  - Advance the counters, cmd innermost:
    - cmd<15: cmd+1.
    - cmd==15: cmd->0, and b+1 (or b->0 and a+1 if b==B_MAX).
  - If a==A_MAX, b==B_MAX and cmd==15 -> DONE; else -> ISSUE with hold counter=0.
- DONE: one cycle.
  - done=1, busy=1, alu_en=0.
  - -> IDLE. Signature and vec_count hold until the next start.
- Timing: each vector occupies HOLD+1 cycles. Total busy cycles = (A_MAX+1)*(B_MAX+1)*16*(HOLD+1)+1, the +1 being the DONE cycle.
- abort in ISSUE/CAPTURE/DONE: next edge -> IDLE.
  - No done pulse; alu_en=0.
  - A CAPTURE coinciding with abort does not update signature/vec_count.
  - Previously captured signature/vec_count are retained.
- start while busy: ignored.
- vec_count width covers the worst case 256*256*16 = 2^20.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- A_MAX=0, B_MAX=0, HOLD=1; bench ALU returns y=16'h0001 constant; start pulse. Required:
  - alu_cmd steps 0..15 with a=b=0, each held 2 cycles.
  - done pulses exactly once, 33 cycles after busy rises.
  - vec_count=16, signature=16'hFFFF.
- Defaults; bench ALU y=16'h0000. Required: vec_count=4096, signature=16'h0000, busy high for 8193 cycles, single done pulse.
- A_MAX=0, B_MAX=1; observe vector order. Required: (a,b,cmd) = (0,0,0)..(0,0,15), then (0,1,0)..(0,1,15), then DONE. vec_count=32.
- Defaults; assert abort during the 6th vector's ISSUE cycle. Required:
  - busy=0 and alu_en=0 after the next edge; no done pulse.
  - vec_count=5; signature equals the fold of the first 5 y values.
- Defaults; drop rst_n mid-sweep between clock edges. Required:
  - All outputs 0 immediately, before the next edge.
  - After release, stays IDLE until start.
  - A fresh start produces a full 4096-vector sweep.
- start asserted while busy: no effect on counters or ordering. start and abort together in IDLE: no sweep begins, busy stays 0.

Source files
------------

// File: rtl/alu_sweep_driver.sv
// Self-test stimulus engine for the 8-bit ALU: walks every (a, b, cmd) vector in order,
// holds each vector for HOLD cycles, then folds the ALU result into a rotate-XOR signature.
module alu_sweep_driver #(
   parameter int A_MAX = 15,
   parameter int B_MAX = 15,
   parameter int HOLD  = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [15:0] alu_y,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic [3:0]  alu_cmd,
   output logic        alu_en,
   output logic        busy,
   output logic        done,
   output logic [15:0] signature,
   output logic [20:0] vec_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_CAPTURE,
      S_DONE
   } state_t;

   localparam int                HOLD_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [7:0]        A_LAST    = 8'(A_MAX);
   localparam logic [7:0]        B_LAST    = 8'(B_MAX);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

   state_t            state;
   logic [HOLD_W-1:0] hold_cnt;
   logic              last_cmd;
   logic              last_b;
   logic              last_a;

   assign last_cmd = (alu_cmd == 4'hF);
   assign last_b   = (alu_b == B_LAST);
   assign last_a   = (alu_a == A_LAST);

   // The operand registers double as the sweep counters, so the ALU sees them directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         hold_cnt  <= '0;
         alu_a     <= 8'd0;
         alu_b     <= 8'd0;
         alu_cmd   <= 4'd0;
         alu_en    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         signature <= 16'd0;
         vec_count <= 21'd0;
      end else begin
         // NOTE: non-blocking assignments so every decision below reads pre-edge values.
         done <= 1'b0;
         if (abort && (state != S_IDLE)) begin
            // Abort drops the vector in flight; signature and count keep what was captured.
            state    <= S_IDLE;
            hold_cnt <= '0;
            alu_a    <= 8'd0;
            alu_b    <= 8'd0;
            alu_cmd  <= 4'd0;
            alu_en   <= 1'b0;
            busy     <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start && !abort) begin
                     state     <= S_ISSUE;
                     hold_cnt  <= '0;
                     alu_a     <= 8'd0;
                     alu_b     <= 8'd0;
                     alu_cmd   <= 4'd0;
                     alu_en    <= 1'b1;
                     busy      <= 1'b1;
                     signature <= 16'd0;
                     vec_count <= 21'd0;
                  end
               end

               S_ISSUE: begin
                  if (hold_cnt == HOLD_LAST) begin
                     state    <= S_CAPTURE;
                     hold_cnt <= '0;
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end

               S_CAPTURE: begin
                  signature <= {signature[14:0], signature[15]} ^ alu_y;
                  vec_count <= vec_count + 21'd1;
                  hold_cnt  <= '0;
                  if (last_a && last_b && last_cmd) begin
                     state   <= S_DONE;
                     alu_a   <= 8'd0;
                     alu_b   <= 8'd0;
                     alu_cmd <= 4'd0;
                     alu_en  <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     state <= S_ISSUE;
                     if (!last_cmd) begin
                        alu_cmd <= alu_cmd + 4'd1;
                     end else begin
                        alu_cmd <= 4'd0;
                        if (!last_b) begin
                           alu_b <= alu_b + 8'd1;
                        end else begin
                           alu_b <= 8'd0;
                           alu_a <= alu_a + 8'd1;
                        end
                     end
                  end
               end

               S_DONE: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end

               default: begin
                  state  <= S_IDLE;
                  alu_en <= 1'b0;
                  busy   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
